// File: rtl/packet_pkg.sv
// Shared packet layout and port FSM encoding for the switch port.
// Packets are packed {data, target, source}.
package packet_pkg;

    localparam int ADDR_WIDTH   = 4;
    localparam int DATA_WIDTH   = 8;
    localparam int PACKET_WIDTH = DATA_WIDTH + 2 * ADDR_WIDTH;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t ROUTE    = 2'd1;
    localparam state_t ARB_WAIT = 2'd2;
    localparam state_t TRANSMIT = 2'd3;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] target;
        logic [ADDR_WIDTH-1:0] source;
    } packet_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and show-ahead head word.
// Push is refused when full even if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/switch_port_vc.sv
// Switch input port: FIFO, route check, arbitration handshake, transmit.
// Define SWITCH_PORT_TIMEOUT_EN to drop heads that wait too long for grant.
module switch_port_vc
    import packet_pkg::*;
#(
    parameter int N_PORTS     = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int PORT_ID     = 0,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic [ADDR_WIDTH-1:0]         source_in,
    input  logic [ADDR_WIDTH-1:0]         target_in,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          grant,
    output logic                          port_req,
    output logic [N_PORTS-1:0]            req_onehot,
    output logic [PACKET_WIDTH-1:0]       pkt_out,
    output logic                          pkt_valid_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_cnt
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (PORT_ID < 0 || PORT_ID >= N_PORTS) begin : g_bad_port_id
        $error("PORT_ID must address one of the N_PORTS ports");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    logic [PACKET_WIDTH-1:0] head_word;
    packet_t                 head;
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    drop;
    logic                    head_ok;
    logic                    timeout_hit;
    state_t                  state;
    state_t                  state_nx;

    sync_fifo #(
        .WIDTH (PACKET_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid_in),
        .pop   (pop),
        .din   ({data_in, target_in, source_in}),
        .full  (full),
        .empty (empty),
        .level (fifo_level),
        .head  (head_word)
    );

    assign head       = head_word;
    assign ready_in   = !full;
    assign head_ok    = (int'(head.target) < N_PORTS) &&
                        (head.target != head.source);
    assign port_req   = (state == ARB_WAIT);
    assign req_onehot = port_req ? (N_PORTS'(1) << head.target) : '0;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        drop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) state_nx = ROUTE;
            end
            ROUTE: begin
                if (head_ok) begin
                    state_nx = ARB_WAIT;
                end else begin
                    pop      = 1'b1;
                    drop     = 1'b1;
                    state_nx = IDLE;
                end
            end
            ARB_WAIT: begin
                // Grant beats a timeout landing in the same cycle.
                if (grant) begin
                    pop      = 1'b1;
                    state_nx = TRANSMIT;
                end else if (timeout_hit) begin
                    pop      = 1'b1;
                    drop     = 1'b1;
                    state_nx = IDLE;
                end
            end
            TRANSMIT: begin
                state_nx = empty ? IDLE : ROUTE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef SWITCH_PORT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] tmo_cnt;

    assign timeout_hit = (state == ARB_WAIT) &&
                         (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state_nx == ARB_WAIT && state != ARB_WAIT) begin
            tmo_cnt <= '0;
        end else if (state == ARB_WAIT && !grant) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pkt_out       <= '0;
            pkt_valid_out <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            state         <= state_nx;
            pkt_valid_out <= (state == ARB_WAIT) && grant;
            if (state == ARB_WAIT && grant) pkt_out <= head;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_switch_port_vc.sv
// Self-checking bench for switch_port_vc: vector table plus scoreboard
// of expected transmitted packets, with multi-cycle corner sequences.
module tb_switch_port_vc;
    import packet_pkg::*;

    localparam int N_PORTS     = 4;
    localparam int FIFO_DEPTH  = 8;
    localparam int TIMEOUT_CYC = 16;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        valid_in = 1'b0;
    logic                        ready_in;
    logic [ADDR_WIDTH-1:0]       source_in = '0;
    logic [ADDR_WIDTH-1:0]       target_in = '0;
    logic [DATA_WIDTH-1:0]       data_in = '0;
    logic                        grant = 1'b0;
    logic                        port_req;
    logic [N_PORTS-1:0]          req_onehot;
    logic [PACKET_WIDTH-1:0]     pkt_out;
    logic                        pkt_valid_out;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic [15:0]                 drop_cnt;

    switch_port_vc #(
        .N_PORTS     (N_PORTS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .PORT_ID     (0),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .ready_in      (ready_in),
        .source_in     (source_in),
        .target_in     (target_in),
        .data_in       (data_in),
        .grant         (grant),
        .port_req      (port_req),
        .req_onehot    (req_onehot),
        .pkt_out       (pkt_out),
        .pkt_valid_out (pkt_valid_out),
        .fifo_level    (fifo_level),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pkts = 0;
    int exp_drop = 0;
    logic [PACKET_WIDTH-1:0] sb [$];

    typedef struct {
        logic [ADDR_WIDTH-1:0] src;
        logic [ADDR_WIDTH-1:0] tgt;
        logic [DATA_WIDTH-1:0] data;
        bit                    exp_valid;
        int                    exp_drop;
    } vec_t;

    vec_t vec [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ADDR_WIDTH-1:0] s,
                        input logic [ADDR_WIDTH-1:0] t,
                        input logic [DATA_WIDTH-1:0] d,
                        input bit expect_tx);
        valid_in  = 1'b1;
        source_in = s;
        target_in = t;
        data_in   = d;
        if (expect_tx) sb.push_back({d, t, s});
        cyc(1);
        valid_in = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (port_req !== 1'b1 && k < 20);
        chk(name, 32'(port_req), 1);
    endtask

    always @(negedge clk) begin
        if (!rst && pkt_valid_out) begin
            n_pkts++;
            chk("pkt_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) chk("pkt_out", 32'(pkt_out), 32'(sb.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit saw_req;
        bit held;

        vec[0] = '{4'd1, 4'd2, 8'h11, 1'b1, 0};
        vec[1] = '{4'd1, 4'd1, 8'h22, 1'b0, 1};
        vec[2] = '{4'd0, 4'd7, 8'h33, 1'b0, 2};
        vec[3] = '{4'd3, 4'd0, 8'h3C, 1'b1, 2};
        vec[4] = '{4'd2, 4'd3, 8'h44, 1'b1, 2};
        vec[5] = '{4'd1, 4'd4, 8'h55, 1'b0, 3};
        vec[6] = '{4'd3, 4'd3, 8'h66, 1'b0, 4};
        vec[7] = '{4'd0, 4'd3, 8'hF0, 1'b1, 4};

        cyc(2);
        @(negedge clk);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ready", 32'(ready_in), 1);
        chk("rst_req", 32'(port_req), 0);
        chk("rst_onehot", 32'(req_onehot), 0);
        chk("rst_pkt_valid", 32'(pkt_valid_out), 0);
        chk("rst_pkt_out", 32'(pkt_out), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        cyc(1);
        rst = 1'b0;
        cyc(1);

        // Latency: word at cycle 0, packet out at cycle 4, grant held high.
        grant = 1'b1;
        send(4'd0, 4'd2, 8'hA5, 1'b1);
        @(negedge clk);
        chk("lat_c1_level", 32'(fifo_level), 1);
        chk("lat_c1_req", 32'(port_req), 0);
        cyc(1);
        @(negedge clk);
        chk("lat_c2_req", 32'(port_req), 0);
        chk("lat_c2_valid", 32'(pkt_valid_out), 0);
        cyc(1);
        @(negedge clk);
        chk("lat_c3_req", 32'(port_req), 1);
        chk("lat_c3_onehot", 32'(req_onehot), 32'b0100);
        chk("lat_c3_valid", 32'(pkt_valid_out), 0);
        cyc(1);
        @(negedge clk);
        chk("lat_c4_valid", 32'(pkt_valid_out), 1);
        chk("lat_c4_req", 32'(port_req), 0);
        chk("lat_c4_onehot", 32'(req_onehot), 0);
        cyc(1);
        @(negedge clk);
        chk("lat_c5_valid", 32'(pkt_valid_out), 0);
        cyc(1);

        for (int i = 0; i < 8; i++) begin
            saw_req = 1'b0;
            send(vec[i].src, vec[i].tgt, vec[i].data, vec[i].exp_valid);
            repeat (8) begin
                @(negedge clk);
                if (port_req) saw_req = 1'b1;
            end
            cyc(1);
            exp_drop = vec[i].exp_drop;
            chk("tbl_drop", 32'(drop_cnt), 32'(exp_drop));
            chk("tbl_req_seen", 32'(saw_req), 32'(vec[i].exp_valid));
            chk("tbl_sb_drained", 32'(sb.size()), 0);
        end

        // Fill to capacity with no grant; ninth word must be refused.
        grant = 1'b0;
        for (int i = 0; i < 9; i++)
            send(4'd0, 4'(1 + i % 3), 8'(8'h80 + i), i < 8);
        @(negedge clk);
        chk("full_level", 32'(fifo_level), FIFO_DEPTH);
        chk("full_ready", 32'(ready_in), 0);
        chk("full_req", 32'(port_req), 1);
        cyc(1);
        n0 = n_pkts;
        grant     = 1'b1;
        valid_in  = 1'b1;
        source_in = 4'd0;
        target_in = 4'd1;
        data_in   = 8'hEE;
        cyc(1);
        valid_in = 1'b0;
        @(negedge clk);
        chk("full_pop_nopush", 32'(fifo_level), FIFO_DEPTH - 1);
        wait_req("pushpop_arb");
        valid_in  = 1'b1;
        source_in = 4'd2;
        target_in = 4'd0;
        data_in   = 8'h77;
        sb.push_back({8'h77, 4'd0, 4'd2});
        cyc(1);
        valid_in = 1'b0;
        @(negedge clk);
        chk("pushpop_level", 32'(fifo_level), FIFO_DEPTH - 1);
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_sb", 32'(sb.size()), 0);
        chk("drain_count", 32'(n_pkts - n0), 9);
        cyc(3);
        chk("drain_level", 32'(fifo_level), 0);
        chk("drain_ready", 32'(ready_in), 1);
        grant = 1'b0;
        cyc(1);

`ifdef SWITCH_PORT_TIMEOUT_EN
        send(4'd0, 4'd1, 8'hC1, 1'b0);
        wait_req("tmo_arb");
        held = 1'b1;
        repeat (TIMEOUT_CYC - 1) begin
            @(negedge clk);
            if (!port_req) held = 1'b0;
        end
        chk("tmo_held", 32'(held), 1);
        @(negedge clk);
        exp_drop++;
        chk("tmo_req_off", 32'(port_req), 0);
        chk("tmo_drop", 32'(drop_cnt), 32'(exp_drop));
        chk("tmo_no_pkt", 32'(pkt_valid_out), 0);
        cyc(2);
        send(4'd0, 4'd2, 8'hC2, 1'b1);
        wait_req("tmo_win_arb");
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        grant = 1'b1;
        cyc(1);
        grant = 1'b0;
        @(negedge clk);
        chk("tmo_grant_wins", 32'(pkt_valid_out), 1);
        chk("tmo_win_drop", 32'(drop_cnt), 32'(exp_drop));
`else
        send(4'd0, 4'd1, 8'hD1, 1'b1);
        wait_req("notmo_arb");
        held = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (!port_req) held = 1'b0;
        end
        chk("notmo_held", 32'(held), 1);
        chk("notmo_drop", 32'(drop_cnt), 32'(exp_drop));
        grant = 1'b1;
        cyc(1);
        grant = 1'b0;
        @(negedge clk);
        chk("notmo_release", 32'(pkt_valid_out), 1);
`endif
        cyc(3);
        chk("pre_rst_sb", 32'(sb.size()), 0);

        // Reset while waiting for grant with three packets queued.
        for (int i = 0; i < 3; i++) send(4'd1, 4'd0, 8'(8'hB0 + i), 1'b0);
        wait_req("rst_arb");
        cyc(1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_level", 32'(fifo_level), 0);
        chk("mrst_ready", 32'(ready_in), 1);
        chk("mrst_req", 32'(port_req), 0);
        chk("mrst_onehot", 32'(req_onehot), 0);
        chk("mrst_valid", 32'(pkt_valid_out), 0);
        chk("mrst_pkt_out", 32'(pkt_out), 0);
        chk("mrst_drop", 32'(drop_cnt), 0);
        n0 = n_pkts;
        cyc(1);
        rst   = 1'b0;
        grant = 1'b1;
        cyc(10);
        chk("mrst_no_pkt", 32'(n_pkts - n0), 0);
        chk("mrst_level_after", 32'(fifo_level), 0);
        chk("mrst_req_after", 32'(port_req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
